// File: rtl/filt_sample_sequencer.sv
// Sample sequencer in front of the filters block: FIFO-buffers XADC samples, runs one filter
// operation per sample and emits each result as a one-cycle strobe. Optional watchdog: FILT_SEQ_TIMEOUT_EN.
module filt_sample_sequencer #(
  parameter int XADC_DATA_SIZE  = 16,
  parameter int FIFO_ADDR_SIZE  = 4,
  parameter int START_PULSE_LEN = 2,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic                      adc_valid,
  input  logic [XADC_DATA_SIZE-1:0] adc_data,
  output logic                      filt_start,
  output logic [XADC_DATA_SIZE-1:0] input_val,
  input  logic                      filt_done,
  input  logic [XADC_DATA_SIZE-1:0] filt_result,
  output logic                      out_valid,
  output logic [XADC_DATA_SIZE-1:0] out_data,
  output logic [FIFO_ADDR_SIZE:0]   fifo_level,
  output logic [15:0]               ovf_cnt,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int DEPTH = 2 ** FIFO_ADDR_SIZE;
  localparam int CNT_W = $clog2(START_PULSE_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t                    state;
  logic [XADC_DATA_SIZE-1:0] mem [DEPTH];
  logic [FIFO_ADDR_SIZE-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          pulse_cnt;
  logic                      done_q, done_pend;
  logic                      full, pop, push, drop, done_rise;

  assign full      = (fifo_level == (FIFO_ADDR_SIZE + 1)'(DEPTH));
  assign pop       = (state == S_IDLE) && en && (fifo_level != '0);
  // A full FIFO still accepts a sample when a pop frees a slot in the same cycle.
  assign push      = adc_valid && (!full || pop);
  assign drop      = adc_valid && !push;
  assign done_rise = filt_done && !done_q;
  assign busy      = (state != S_IDLE);

  // NOTE: sample storage has no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= adc_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ovf_cnt    <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= filt_done;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !push) fifo_level <= fifo_level - 1'b1;
      if (drop && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

`ifdef FILT_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] wait_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      filt_start  <= 1'b0;
      input_val   <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      pulse_cnt   <= '0;
      done_pend   <= 1'b0;
`ifdef FILT_SEQ_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
`ifdef FILT_SEQ_TIMEOUT_EN
      if (!en) timeout_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          done_pend <= 1'b0;
          if (pop) begin
            // Read-first: a same-cycle push to this slot cannot disturb the popped value.
            input_val  <= mem[rd_ptr];
            filt_start <= 1'b1;
            pulse_cnt  <= CNT_W'(1);
            state      <= S_START;
          end
        end
        S_START: begin
          if (done_rise) done_pend <= 1'b1;
          if (pulse_cnt == CNT_W'(START_PULSE_LEN)) begin
            filt_start <= 1'b0;
`ifdef FILT_SEQ_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
            state      <= S_WAIT;
          end else begin
            pulse_cnt <= pulse_cnt + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (done_rise || done_pend) begin
            out_data  <= filt_result;
            out_valid <= 1'b1;
            done_pend <= 1'b0;
            state     <= S_IDLE;
          end
`ifdef FILT_SEQ_TIMEOUT_EN
          else if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filt_sample_sequencer.sv
// Directed bench for filt_sample_sequencer with a delayed-done filter model (result = sample ^ 16'h1888)
// and a manual done/result override for edge-case steps.
module tb_filt_sample_sequencer;

  localparam int TO = 64;
`ifdef FILT_SEQ_TIMEOUT_EN
  localparam int T2_DELAY = 40;
`else
  localparam int T2_DELAY = 300;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        adc_valid = 1'b0;
  logic [15:0] adc_data = '0;
  logic        filt_start;
  logic [15:0] input_val;
  logic        filt_done;
  logic [15:0] filt_result;
  logic        out_valid;
  logic [15:0] out_data;
  logic [4:0]  fifo_level;
  logic [15:0] ovf_cnt;
  logic        busy;
  logic        timeout_err;

  logic        manual_mode = 1'b0;
  logic        manual_done = 1'b0;
  logic [15:0] manual_result = '0;
  logic        model_done = 1'b0;
  logic [15:0] model_result = '0;
  logic        m_start_q = 1'b0;
  int          m_cnt = 0;
  int          model_delay = 30;

  int          n_checks = 0;
  int          n_fail = 0;
  int          start_cnt = 0;
  int          start_hi = 0;
  int          out_cnt = 0;
  logic        start_prev = 1'b0;
  logic [15:0] outs[$];

  always #5 clk = ~clk;

  assign filt_done   = manual_mode ? manual_done : model_done;
  assign filt_result = manual_mode ? manual_result : model_result;

  filt_sample_sequencer #(
    .XADC_DATA_SIZE(16), .FIFO_ADDR_SIZE(4), .START_PULSE_LEN(2), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .adc_valid(adc_valid), .adc_data(adc_data),
    .filt_start(filt_start), .input_val(input_val), .filt_done(filt_done),
    .filt_result(filt_result), .out_valid(out_valid), .out_data(out_data),
    .fifo_level(fifo_level), .ovf_cnt(ovf_cnt), .busy(busy), .timeout_err(timeout_err)
  );

  // Filter model: one-cycle done pulse model_delay cycles after each filt_start rise.
  always @(posedge clk) begin
    m_start_q <= filt_start;
    model_done <= 1'b0;
    if (filt_start && !m_start_q) begin
      m_cnt        <= model_delay;
      model_result <= input_val ^ 16'h1888;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) model_done <= 1'b1;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (filt_start) start_hi++;
    if (filt_start && !start_prev) start_cnt++;
    start_prev = filt_start;
    if (out_valid) begin
      out_cnt++;
      outs.push_back(out_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [15:0] v);
    adc_valid = 1'b1;
    adc_data  = v;
    @(negedge clk);
    adc_valid = 1'b0;
  endtask

  task automatic wait_out(input int target, input int budget, input string tag);
    int n = 0;
    while (out_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(out_cnt >= target), 32'd1);
  endtask

  initial begin
    int s0, h0, o0;

    // Reset state
    tick(3);
    check("rst_filt_start", 32'(filt_start), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ovf", 32'(ovf_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    en   = 1'b1;
    tick(2);

    // Single operation
    model_delay = T2_DELAY;
    h0 = start_hi; o0 = out_cnt;
    push(16'h1234);
    tick(40);
    check("t2_input_val_wait", 32'(input_val), 32'h1234);
    check("t2_busy", 32'(busy), 32'd1);
    wait_out(o0 + 1, T2_DELAY + 50, "t2_out_timeout");
    tick(5);
    check("t2_start_high_cycles", 32'(start_hi - h0), 32'd2);
    check("t2_input_val_held", 32'(input_val), 32'h1234);
    check("t2_out_count", 32'(out_cnt - o0), 32'd1);
    check("t2_out_data", 32'(outs[o0]), 32'h0ABC);

    // Burst of 20 into a busy sequencer
    model_delay = 30;
    o0 = out_cnt;
    for (int i = 1; i <= 20; i++) push(16'(i));
    check("t3_level_full", 32'(fifo_level), 32'd16);
    check("t3_ovf", 32'(ovf_cnt), 32'd3);
    wait_out(o0 + 17, 2000, "t3_out_timeout");
    tick(50);
    check("t3_out_count", 32'(out_cnt - o0), 32'd17);
    for (int i = 0; i < 17; i++)
      check($sformatf("t3_order_%0d", i + 1), 32'(outs[o0 + i]), 32'(16'(i + 1) ^ 16'h1888));
    check("t3_level_empty", 32'(fifo_level), 32'd0);

    // en dropped during WAIT with four samples queued
    o0 = out_cnt;
    s0 = start_cnt;
    for (int i = 1; i <= 5; i++) push(16'hA000 + 16'(i));
    check("t4_level4", 32'(fifo_level), 32'd4);
    tick(5);
    en = 1'b0;
    wait_out(o0 + 1, 100, "t4_out_timeout");
    tick(20);
    check("t4_out_count", 32'(out_cnt - o0), 32'd1);
    check("t4_out_data", 32'(outs[o0]), 32'(16'hA001 ^ 16'h1888));
    check("t4_level_held", 32'(fifo_level), 32'd4);
    check("t4_no_new_start", 32'(start_cnt - s0), 32'd1);
    en = 1'b1;
    tick(1);
    check("t4_resume_start", 32'(filt_start), 32'd1);
    check("t4_resume_level", 32'(fifo_level), 32'd3);
    check("t4_resume_val", 32'(input_val), 32'hA002);
    wait_out(o0 + 5, 500, "t4_rest_timeout");
    tick(5);
    check("t4_last", 32'(outs[o0 + 4]), 32'(16'hA005 ^ 16'h1888));

    // filt_done already high at start
    manual_mode   = 1'b1;
    manual_done   = 1'b1;
    manual_result = 16'h5555;
    tick(2);
    o0 = out_cnt;
    push(16'h0777);
    tick(30);
    check("t5_no_out_level_done", 32'(out_cnt - o0), 32'd0);
    check("t5_busy", 32'(busy), 32'd1);
    manual_done = 1'b0;
    tick(2);
    manual_done = 1'b1;
    tick(3);
    check("t5_one_out", 32'(out_cnt - o0), 32'd1);
    check("t5_out_data", 32'(out_data), 32'h5555);
    tick(10);
    check("t5_no_dup", 32'(out_cnt - o0), 32'd1);
    manual_done = 1'b0;
    tick(2);

    // Reset asserted during WAIT with level=5
    push(16'h0BAD);
    tick(10);
    for (int i = 1; i <= 5; i++) push(16'hC000 + 16'(i));
    check("t1_level5", 32'(fifo_level), 32'd5);
    check("t1_busy_pre", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    check("t1_filt_start", 32'(filt_start), 32'd0);
    check("t1_input_val", 32'(input_val), 32'd0);
    check("t1_out_valid", 32'(out_valid), 32'd0);
    check("t1_out_data", 32'(out_data), 32'd0);
    check("t1_level", 32'(fifo_level), 32'd0);
    check("t1_ovf", 32'(ovf_cnt), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_timeout_err", 32'(timeout_err), 32'd0);
    tick(1);
    rstn = 1'b1;
    s0 = start_cnt;
    tick(20);
    check("t1_no_start_after_rst", 32'(start_cnt - s0), 32'd0);
    check("t1_idle_after_rst", 32'(busy), 32'd0);
    adc_valid = 1'b1;
    adc_data  = 16'h4321;
    tick(1);
    adc_valid = 1'b0;
    tick(1);
    check("t1_start_after_sample", 32'(filt_start), 32'd1);
    check("t1_input_val_new", 32'(input_val), 32'h4321);

    // Filter never answers
    o0 = out_cnt;
    tick(TO + 10);
`ifdef FILT_SEQ_TIMEOUT_EN
    check("t6_timeout_err", 32'(timeout_err), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
`else
    check("t6_timeout_err", 32'(timeout_err), 32'd0);
    check("t6_busy", 32'(busy), 32'd1);
`endif
    check("t6_no_out", 32'(out_cnt - o0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
